// File: rtl/dds_gen.sv
// -----------------------------------------------------------------------------
// dds_gen : parametrised direct digital synthesis generator
//
// A PHASE_W-bit phase accumulator advances by a programmable tuning word.
// The phase (accumulator plus a programmable offset) is shaped into one of
// four waveforms (sine, square, triangle, sawtooth). The result is an
// offset-binary sample on dac_data. The sine uses an external synchronous
// quarter-wave ROM. A waveform change only takes effect at a phase wrap,
// or while the accumulator is idle or being cleared, so a running period
// is never cut.
//
// Ports
//   sys_clk     : system clock
//   sys_rst     : asynchronous active-high reset
//   en          : accumulator advance enable
//   sync_clr    : synchronous accumulator clear (wins over en)
//   cfg_load    : one-cycle strobe, latches freq_word and phase_off
//   freq_word   : frequency tuning word
//   phase_off   : phase offset added after the accumulator
//   wave_sel    : one-hot select, bit0 sine, bit1 square, bit2 triangle,
//                 bit3 sawtooth; other codes are ignored
//   rom_addr    : quarter-wave ROM address (registered)
//   rom_data    : ROM sample, valid one cycle after rom_addr
//   wrap        : one-cycle pulse on accumulator carry-out
//   data_valid  : dac_data carries a live sample
//   dac_clk     : inverted system clock for the DAC
//   dac_data    : offset-binary DAC sample
//
// Pipeline (edge k updates the accumulator):
//   k+1 : phase fold -> rom_addr, sign, mode, non-sine value
//   k+2 : ROM returns data; non-sine value delayed to match
//   k+3 : dac_data register
// -----------------------------------------------------------------------------
module dds_gen #(
    parameter int PHASE_W = 32,
    parameter int ADDR_W  = 10,
    parameter int DATA_W  = 8
) (
    input  logic                sys_clk,
    input  logic                sys_rst,
    input  logic                en,
    input  logic                sync_clr,
    input  logic                cfg_load,
    input  logic [PHASE_W-1:0]  freq_word,
    input  logic [PHASE_W-1:0]  phase_off,
    input  logic [3:0]          wave_sel,
    output logic [ADDR_W-3:0]   rom_addr,
    input  logic [DATA_W-2:0]   rom_data,
    output logic                wrap,
    output logic                data_valid,
    output logic                dac_clk,
    output logic [DATA_W-1:0]   dac_data
);

    // Mid-scale code of the offset-binary output.
    localparam logic [DATA_W-1:0] MID = {1'b1, {(DATA_W-1){1'b0}}};

    typedef enum logic [1:0] {
        MODE_SINE   = 2'd0,
        MODE_SQUARE = 2'd1,
        MODE_TRI    = 2'd2,
        MODE_SAW    = 2'd3
    } mode_t;

    // -------------------------------------------------------------------------
    // Helpers
    // -------------------------------------------------------------------------

    // Fold a full-wave phase index onto the quarter-wave table: odd quadrants
    // run the table backwards.
    function automatic logic [ADDR_W-3:0] fold_addr(input logic [ADDR_W-1:0] a);
        logic [ADDR_W-3:0] res;
        if (a[ADDR_W-2]) begin
            res = ~a[ADDR_W-3:0];
        end else begin
            res = a[ADDR_W-3:0];
        end
        return res;
    endfunction

    // Square, triangle and sawtooth taken straight from the phase word.
    // The sine value comes from the ROM, so it yields zero here.
    function automatic logic [DATA_W-1:0] shape(input mode_t m,
                                                input logic [PHASE_W-1:0] p);
        logic [DATA_W-1:0] t;
        logic [DATA_W-1:0] res;
        t = p[PHASE_W-2 -: DATA_W];
        case (m)
            MODE_SQUARE: res = {DATA_W{p[PHASE_W-1]}};
            MODE_TRI:    res = p[PHASE_W-1] ? ~t : t;
            MODE_SAW:    res = p[PHASE_W-1 -: DATA_W];
            default:     res = {DATA_W{1'b0}};
        endcase
        return res;
    endfunction

    // Sine reconstruction from a quarter-wave magnitude. The first half
    // period gives MID + m. The second half gives MID - 1 - m, which in
    // offset binary is just the inverted magnitude with a clear MSB.
    function automatic logic [DATA_W-1:0] sine_out(input logic sign,
                                                   input logic [DATA_W-2:0] m);
        logic [DATA_W-1:0] res;
        if (sign) begin
            res = {1'b0, ~m};
        end else begin
            res = {1'b1, m};
        end
        return res;
    endfunction

    // -------------------------------------------------------------------------
    // Registers and wires
    // -------------------------------------------------------------------------
    logic [PHASE_W-1:0] r_acc;
    logic [PHASE_W-1:0] r_fw;
    logic [PHASE_W-1:0] r_po;
    mode_t              r_mode_pend;
    mode_t              r_mode;

    logic               r_s1_sign;
    mode_t              r_s1_mode;
    logic [DATA_W-1:0]  r_s1_val;
    logic               r_s2_sign;
    mode_t              r_s2_mode;
    logic [DATA_W-1:0]  r_s2_val;

    logic               r_v0;
    logic               r_v1;
    logic               r_v2;

    logic               w_sel_legal;
    mode_t              w_sel_mode;
    mode_t              w_mode_pend_next;
    logic [PHASE_W:0]   w_sum;
    logic               w_carry;
    logic               w_commit;
    logic [PHASE_W-1:0] w_phase;
    logic [ADDR_W-1:0]  w_a;
    logic [DATA_W-1:0]  w_dac_next;

    // The DAC latches on the falling system clock edge, which is when
    // dac_data is stable.
    assign dac_clk = ~sys_clk;

    // -------------------------------------------------------------------------
    // Waveform select decode
    // -------------------------------------------------------------------------

    // Decode one-hot wave_sel; anything else keeps the pending mode.
    always_comb begin
        w_sel_legal = 1'b1;
        w_sel_mode  = r_mode_pend;
        case (wave_sel)
            4'b0001: w_sel_mode = MODE_SINE;
            4'b0010: w_sel_mode = MODE_SQUARE;
            4'b0100: w_sel_mode = MODE_TRI;
            4'b1000: w_sel_mode = MODE_SAW;
            default: begin
                w_sel_legal = 1'b0;
                w_sel_mode  = r_mode_pend;
            end
        endcase
        if (w_sel_legal) begin
            w_mode_pend_next = w_sel_mode;
        end else begin
            w_mode_pend_next = r_mode_pend;
        end
    end

    // -------------------------------------------------------------------------
    // Accumulator and mode commit
    // -------------------------------------------------------------------------
    assign w_sum   = {1'b0, r_acc} + {1'b0, r_fw};
    assign w_carry = w_sum[PHASE_W];

    // The carry term is only relevant while running. When the accumulator
    // is idle or being cleared, the commit happens regardless.
    assign w_commit = sync_clr | ~en | w_carry;

    // Tuning word and phase offset, latched on the config strobe.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_fw <= {PHASE_W{1'b0}};
            r_po <= {PHASE_W{1'b0}};
        end else if (cfg_load) begin
            r_fw <= freq_word;
            r_po <= phase_off;
        end
    end

    // Phase accumulator with clear priority and the wrap pulse.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_acc <= {PHASE_W{1'b0}};
            wrap  <= 1'b0;
        end else if (sync_clr) begin
            r_acc <= {PHASE_W{1'b0}};
            wrap  <= 1'b0;
        end else if (en) begin
            r_acc <= w_sum[PHASE_W-1:0];
            wrap  <= w_carry;
        end else begin
            wrap  <= 1'b0;
        end
    end

    // Pending and committed waveform mode.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_mode_pend <= MODE_SAW;
            r_mode      <= MODE_SAW;
        end else begin
            r_mode_pend <= w_mode_pend_next;
            if (w_commit) begin
                r_mode <= w_mode_pend_next;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Stage 1: phase offset, ROM address fold, non-sine shaping
    // -------------------------------------------------------------------------
    assign w_phase = r_acc + r_po;
    assign w_a     = w_phase[PHASE_W-1 -: ADDR_W];

    // Stage 1 register: ROM address, half-period sign, mode, shaped value.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            rom_addr  <= {(ADDR_W-2){1'b0}};
            r_s1_sign <= 1'b0;
            r_s1_mode <= MODE_SAW;
            r_s1_val  <= {DATA_W{1'b0}};
        end else begin
            rom_addr  <= fold_addr(w_a);
            r_s1_sign <= w_a[ADDR_W-1];
            r_s1_mode <= r_mode;
            r_s1_val  <= shape(r_mode, w_phase);
        end
    end

    // -------------------------------------------------------------------------
    // Stage 2: wait for the ROM read
    // -------------------------------------------------------------------------

    // Stage 2 register: carry sign, mode and shaped value alongside the ROM.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_s2_sign <= 1'b0;
            r_s2_mode <= MODE_SAW;
            r_s2_val  <= {DATA_W{1'b0}};
        end else begin
            r_s2_sign <= r_s1_sign;
            r_s2_mode <= r_s1_mode;
            r_s2_val  <= r_s1_val;
        end
    end

    // -------------------------------------------------------------------------
    // Stage 3: output select
    // -------------------------------------------------------------------------

    // Pick the ROM-based sine or the delayed non-sine value.
    always_comb begin
        w_dac_next = r_s2_val;
        if (r_s2_mode == MODE_SINE) begin
            w_dac_next = sine_out(r_s2_sign, rom_data);
        end else begin
            w_dac_next = r_s2_val;
        end
    end

    // Output sample register; reset parks the DAC at mid-scale.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            dac_data <= MID;
        end else begin
            dac_data <= w_dac_next;
        end
    end

    // Valid chain: the enable seen at an accumulator update travels with
    // that sample to the output.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_v0       <= 1'b0;
            r_v1       <= 1'b0;
            r_v2       <= 1'b0;
            data_valid <= 1'b0;
        end else begin
            r_v0       <= en;
            r_v1       <= r_v0;
            r_v2       <= r_v1;
            data_valid <= r_v2;
        end
    end

endmodule

// File: tb/tb_dds_gen.sv
// -----------------------------------------------------------------------------
// tb_dds_gen : self-checking bench for dds_gen (PHASE_W=32, ADDR_W=10,
// DATA_W=8).
//
// A behavioural model computes each expected sample from the phase with
// plain arithmetic. A delay line aligns that sample with the three-edge
// output latency. One compare process checks every output on each falling
// edge. Directed phases pin literal values: reset, the saw wrap alignment,
// and the sine peak and trough. A randomized phase follows the directed
// ones.
// -----------------------------------------------------------------------------
module tb_dds_gen;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic        en;
    logic        sync_clr;
    logic        cfg_load;
    logic [31:0] freq_word;
    logic [31:0] phase_off;
    logic [3:0]  wave_sel;
    logic [7:0]  rom_addr;
    logic [6:0]  rom_data;
    logic        wrap;
    logic        data_valid;
    logic        dac_clk;
    logic [7:0]  dac_data;

    int n_vec = 0;
    int n_err = 0;

    dds_gen #(.PHASE_W(32), .ADDR_W(10), .DATA_W(8)) dut (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .en         (en),
        .sync_clr   (sync_clr),
        .cfg_load   (cfg_load),
        .freq_word  (freq_word),
        .phase_off  (phase_off),
        .wave_sel   (wave_sel),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .wrap       (wrap),
        .data_valid (data_valid),
        .dac_clk    (dac_clk),
        .dac_data   (dac_data)
    );

    always #5 sys_clk = ~sys_clk;

    // Quarter-wave ROM contents and a synchronous read port.
    logic [6:0] rom_tbl [0:255];
    initial begin
        for (int i = 0; i < 256; i++) begin
            rom_tbl[i] = 7'($rtoi(127.0 * $sin((i + 0.5) * 3.141592653589793 / 512.0) + 0.5));
        end
    end
    always @(posedge sys_clk) rom_data <= rom_tbl[rom_addr];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------------------------------------------------------------
    // Behavioural model
    // ---------------------------------------------------------------------

    // Waveform value for a phase word, computed from the waveform rules.
    function automatic logic [7:0] sample_of(input logic [31:0] ph, input logic [3:0] mode);
        int unsigned a, q, r, idx, u;
        logic [7:0] res;
        a = ph >> 22;
        q = a / 256;
        r = a % 256;
        idx = (q % 2 == 1) ? 255 - r : r;
        u = ph >> 23;
        case (mode)
            4'b0001: res = (q >= 2) ? 8'(127 - int'(rom_tbl[idx])) : 8'(128 + int'(rom_tbl[idx]));
            4'b0010: res = (ph >= 32'h8000_0000) ? 8'd255 : 8'd0;
            4'b0100: res = (u < 256) ? 8'(u) : 8'(511 - u);
            default: res = 8'(ph >> 24);
        endcase
        return res;
    endfunction

    function automatic logic [7:0] addr_of(input logic [31:0] ph);
        int unsigned a, r;
        a = ph >> 22;
        r = a % 256;
        return ((a / 256) % 2 == 1) ? 8'(255 - r) : 8'(r);
    endfunction

    logic [31:0] m_acc, m_fw, m_po;
    logic [3:0]  m_pend, m_mode;
    logic        m_wrap;
    logic [7:0]  m_addr, m_s1, m_s2, m_dac;
    logic        m_v0, m_v1, m_v2, m_dv;
    logic [3:0]  m_pnext;
    logic [32:0] m_sum;

    assign m_pnext = ($countones(wave_sel) == 1) ? wave_sel : m_pend;
    assign m_sum   = {1'b0, m_acc} + {1'b0, m_fw};

    // Model state update on each clock edge, reset asynchronously.
    always @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            m_acc <= 32'd0; m_fw <= 32'd0; m_po <= 32'd0;
            m_pend <= 4'b1000; m_mode <= 4'b1000; m_wrap <= 1'b0;
            m_addr <= 8'd0; m_s1 <= 8'd0; m_s2 <= 8'd0; m_dac <= 8'd128;
            m_v0 <= 1'b0; m_v1 <= 1'b0; m_v2 <= 1'b0; m_dv <= 1'b0;
        end else begin
            if (cfg_load) begin
                m_fw <= freq_word;
                m_po <= phase_off;
            end
            if (sync_clr) begin
                m_acc <= 32'd0; m_wrap <= 1'b0;
            end else if (en) begin
                m_acc <= m_sum[31:0]; m_wrap <= m_sum[32];
            end else begin
                m_wrap <= 1'b0;
            end
            m_pend <= m_pnext;
            if (sync_clr || !en || m_sum[32]) m_mode <= m_pnext;
            m_addr <= addr_of(m_acc + m_po);
            m_s1 <= sample_of(m_acc + m_po, m_mode);
            m_s2 <= m_s1;
            m_dac <= m_s2;
            m_v0 <= en; m_v1 <= m_v0; m_v2 <= m_v1; m_dv <= m_v2;
        end
    end

    // Compare process: every output against the model on each falling edge.
    always @(negedge sys_clk) begin
        chk("dac_clk_lo", 32'(dac_clk), 32'd1);
        chk("wrap", 32'(wrap), 32'(m_wrap));
        chk("rom_addr", 32'(rom_addr), 32'(m_addr));
        chk("data_valid", 32'(data_valid), 32'(m_dv));
        if (m_dv || sys_rst) chk("dac_data", 32'(dac_data), 32'(m_dac));
    end

    // dac_clk must also be low while sys_clk is high.
    always @(posedge sys_clk) begin
        #1;
        chk("dac_clk_hi", 32'(dac_clk), 32'd0);
    end

    // ---------------------------------------------------------------------
    // Stimulus
    // ---------------------------------------------------------------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge sys_clk);
            #2;
        end
    endtask

    initial begin : stim
        logic found;
        logic [7:0] mx, mn;
        en = 1'b0; sync_clr = 1'b0; cfg_load = 1'b0;
        freq_word = 32'd0; phase_off = 32'd0; wave_sel = 4'b0000;

        // Reset held for three cycles
        repeat (3) @(posedge sys_clk);
        @(negedge sys_clk);
        chk("rst_dac", 32'(dac_data), 32'd128);
        chk("rst_addr", 32'(rom_addr), 32'd0);
        chk("rst_wrap", 32'(wrap), 32'd0);
        chk("rst_valid", 32'(data_valid), 32'd0);
        tick(1);
        sys_rst = 1'b0;

        // Sawtooth at fw=2^24, restarted from phase 0
        freq_word = 32'h0100_0000; phase_off = 32'd0; cfg_load = 1'b1; wave_sel = 4'b1000;
        tick(1);
        cfg_load = 1'b0; sync_clr = 1'b1; en = 1'b1;
        tick(1);
        sync_clr = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge sys_clk);
            if (wrap) begin
                found = 1'b1;
                break;
            end
        end
        chk("saw_wrap_seen", 32'(found), 32'd1);
        @(negedge sys_clk);
        @(negedge sys_clk);
        chk("saw_top", 32'(dac_data), 32'd255);
        @(negedge sys_clk);
        chk("saw_zero", 32'(dac_data), 32'd0);
        tick(1);

        // Switch to sine mid-period: commits at the next wrap
        tick(95);
        wave_sel = 4'b0001;
        tick(400);

        // Phase offset of half a turn inverts the sine
        phase_off = 32'h8000_0000; cfg_load = 1'b1;
        tick(1);
        cfg_load = 1'b0;
        tick(300);

        // Sine at fw=2^22 over a full period: peak and trough
        freq_word = 32'h0040_0000; phase_off = 32'd0; cfg_load = 1'b1; sync_clr = 1'b1;
        tick(1);
        cfg_load = 1'b0; sync_clr = 1'b0;
        mx = 8'd0; mn = 8'd255;
        for (int i = 0; i < 1100; i++) begin
            @(negedge sys_clk);
            if (data_valid) begin
                if (dac_data > mx) mx = dac_data;
                if (dac_data < mn) mn = dac_data;
            end
        end
        chk("sine_peak", 32'(mx), 32'd255);
        chk("sine_trough", 32'(mn), 32'd0);
        tick(1);

        // Square at fw=2^30
        wave_sel = 4'b0010; en = 1'b0; freq_word = 32'h4000_0000; cfg_load = 1'b1;
        tick(1);
        cfg_load = 1'b0; en = 1'b1; sync_clr = 1'b1;
        tick(1);
        sync_clr = 1'b0;
        tick(40);

        // Triangle at fw=2^25
        wave_sel = 4'b0100; en = 1'b0; freq_word = 32'h0200_0000; cfg_load = 1'b1;
        tick(1);
        cfg_load = 1'b0; en = 1'b1;
        tick(300);

        // Clear mid-period while running, then while idle
        sync_clr = 1'b1;
        tick(1);
        sync_clr = 1'b0;
        tick(60);
        en = 1'b0; sync_clr = 1'b1;
        tick(1);
        sync_clr = 1'b0;
        tick(6);

        // Non-one-hot select keeps the triangle
        wave_sel = 4'b0110;
        tick(3);
        en = 1'b1;
        tick(100);

        // Reset in the middle of a sine
        wave_sel = 4'b0001; en = 1'b0; freq_word = 32'h0040_0000; cfg_load = 1'b1;
        tick(1);
        cfg_load = 1'b0; en = 1'b1;
        tick(50);
        sys_rst = 1'b1;
        @(negedge sys_clk);
        chk("midrst_dac", 32'(dac_data), 32'd128);
        chk("midrst_valid", 32'(data_valid), 32'd0);
        tick(2);
        sys_rst = 1'b0;
        cfg_load = 1'b1;
        tick(1);
        cfg_load = 1'b0;
        tick(40);

        // Randomized operation
        for (int i = 0; i < 3000; i++) begin
            en = ($urandom_range(0, 7) != 0);
            sync_clr = ($urandom_range(0, 99) == 0);
            cfg_load = ($urandom_range(0, 39) == 0);
            freq_word = $urandom >> $urandom_range(4, 14);
            phase_off = $urandom;
            if ($urandom_range(0, 29) == 0) wave_sel = 4'($urandom_range(0, 15));
            else if ($urandom_range(0, 29) == 0) wave_sel = 4'b0001 << $urandom_range(0, 3);
            tick(1);
        end
        en = 1'b0; sync_clr = 1'b0; cfg_load = 1'b0;
        tick(5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
